// File: rtl/alu_result_skid_stage.sv
// EX->MEM stage after the ALU: two-entry skid buffer with a registered in_ready,
// branch-taken resolution at capture and a saturating back-pressure counter.
module alu_result_skid_stage #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_zero,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic              in_branch,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              out_zero,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_take,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic accept;
   logic pop;
   logic load_h;
   logic load_s;
   logic shift_s;

   logic [DATA_W-1:0] h_result;
   logic              h_zero;
   logic [TAG_W-1:0]  h_tag;
   logic              h_take;
   logic [DATA_W-1:0] s_result;
   logic              s_zero;
   logic [TAG_W-1:0]  s_tag;
   logic              s_take;

   // Handshake flags come only from the registered state, so in_ready never sees out_ready.
   assign in_ready  = (state_q != TWO);
   assign out_valid = (state_q != EMPTY);
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      load_h  = 1'b0;
      load_s  = 1'b0;
      shift_s = 1'b0;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               load_h  = 1'b1;
            end
         end
         ONE: begin
            if (accept && pop) begin
               load_h = 1'b1;
            end else if (accept) begin
               state_d = TWO;
               load_s  = 1'b1;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               state_d = ONE;
               shift_s = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush wins over everything; the word offered in this cycle is dropped.
      if (flush) begin
         state_d = EMPTY;
         load_h  = 1'b0;
         load_s  = 1'b0;
         shift_s = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_result <= '0;
         h_zero   <= 1'b0;
         h_tag    <= '0;
         h_take   <= 1'b0;
      end else if (load_h) begin
         h_result <= in_result;
         h_zero   <= in_zero;
         h_tag    <= in_tag;
         h_take   <= in_branch & in_zero;
      end else if (shift_s) begin
         h_result <= s_result;
         h_zero   <= s_zero;
         h_tag    <= s_tag;
         h_take   <= s_take;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_result <= '0;
         s_zero   <= 1'b0;
         s_tag    <= '0;
         s_take   <= 1'b0;
      end else if (load_s) begin
         s_result <= in_result;
         s_zero   <= in_zero;
         s_tag    <= in_tag;
         s_take   <= in_branch & in_zero;
      end
   end

   // Counts every back-pressured cycle, flush included, and sticks at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign out_result = h_result;
   assign out_zero   = h_zero;
   assign out_tag    = h_tag;
   assign out_take   = h_take;

endmodule

// File: tb/tb_alu_result_skid_stage.sv
// Scoreboard bench for alu_result_skid_stage: a queue model of the two-entry
// buffer predicts handshake flags, output order/contents and the stall counter.
module tb_alu_result_skid_stage;

   localparam int DATA_W = 32;
   localparam int TAG_W  = 5;
   localparam int CNT_W  = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef struct {
      logic [DATA_W-1:0] result;
      logic              zero;
      logic [TAG_W-1:0]  tag;
      logic              take;
   } entry_t;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_result;
   logic              in_zero;
   logic [TAG_W-1:0]  in_tag;
   logic              in_branch;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic              out_zero;
   logic [TAG_W-1:0]  out_tag;
   logic              out_take;
   logic [CNT_W-1:0]  stall_cnt;

   entry_t model_q[$];
   int     exp_stall;
   int     num_checks;
   int     num_errors;

   alu_result_skid_stage #(
      .DATA_W(DATA_W),
      .TAG_W (TAG_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_result (in_result),
      .in_zero   (in_zero),
      .in_tag    (in_tag),
      .in_branch (in_branch),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_result(out_result),
      .out_zero  (out_zero),
      .out_tag   (out_tag),
      .out_take  (out_take),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      num_checks++;
      if (observed !== expected) begin
         num_errors++;
         $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Holds reset for two edges with in_valid high; the model forgets everything.
   task automatic applyReset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_result = 32'hDEAD_BEEF;
      in_zero   = 1'b0;
      in_tag    = 5'd9;
      in_branch = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      model_q.delete();
      exp_stall = 0;
   endtask

   // Drives one cycle of inputs, checks the DUT against the model before the edge,
   // then advances the model across the edge.
   task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t,
                                input logic br, input logic ordy, input logic fl);
      entry_t e;
      entry_t head;
      bit     do_pop;
      bit     do_accept;
      in_valid  = v;
      in_result = d;
      in_zero   = (d == '0);
      in_tag    = t;
      in_branch = br;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      checkOutput("in_ready", 64'(in_ready), 64'(model_q.size() != 2));
      checkOutput("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
      checkOutput("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      do_pop    = (model_q.size() != 0) && ordy;
      do_accept = v && (model_q.size() < 2) && !fl;
      if ((model_q.size() != 0) && !ordy && (exp_stall != CNT_MAX)) exp_stall++;
      if (do_pop) begin
         head = model_q.pop_front();
         checkOutput("out_result", 64'(out_result), 64'(head.result));
         checkOutput("out_zero", 64'(out_zero), 64'(head.zero));
         checkOutput("out_tag", 64'(out_tag), 64'(head.tag));
         checkOutput("out_take", 64'(out_take), 64'(head.take));
      end
      if (fl) model_q.delete();
      if (do_accept) begin
         e.result = d;
         e.zero   = (d == '0);
         e.tag    = t;
         e.take   = br && (d == '0);
         model_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      num_checks = 0;
      num_errors = 0;
      exp_stall  = 0;

      // Reset with in_valid asserted: nothing captured, outputs cleared.
      applyReset();
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("rst_out_result", 64'(out_result), 64'd0);
      checkOutput("rst_out_zero", 64'(out_zero), 64'd0);
      checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
      checkOutput("rst_out_take", 64'(out_take), 64'd0);
      checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);

      // Streaming with MEM always ready.
      applyStimulus(1'b1, 32'h0000_0005, 5'd1, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'hFFFF_FFFF, 5'd2, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h0000_0000, 5'd3, 1'b0, 1'b1, 1'b0);
      repeat (2) applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);

      // Skid: fill both entries under back-pressure, offer a third word, then drain.
      applyStimulus(1'b1, 32'h0000_0011, 5'd4, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0000_0022, 5'd5, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0000_0033, 5'd6, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);

      // Branch resolution captured with each entry.
      applyStimulus(1'b1, 32'h0000_0000, 5'd7, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h0000_0007, 5'd8, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h0000_0000, 5'd9, 1'b0, 1'b1, 1'b0);
      repeat (2) applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);

      // Flush while full, with a word offered in the flush cycle.
      applyStimulus(1'b1, 32'h0000_00A1, 5'd10, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0000_00A2, 5'd11, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0000_00A3, 5'd12, 1'b0, 1'b0, 1'b1);
      repeat (3) applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h0000_00B1, 5'd13, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);

      // Reset mid-operation drops held entries.
      applyStimulus(1'b1, 32'h0000_00C1, 5'd14, 1'b0, 1'b0, 1'b0);
      applyReset();
      checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("midrst_stall_cnt", 64'(stall_cnt), 64'd0);

      // Stall counter saturation.
      applyStimulus(1'b1, 32'h0000_0042, 5'd15, 1'b0, 1'b0, 1'b0);
      repeat (20) applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));
      applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 300; i++) begin
         logic [DATA_W-1:0] d;
         d = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom);
         applyStimulus(1'($urandom_range(0, 1)), d, TAG_W'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 15) == 0));
      end

      repeat (3) applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("drained", 64'(model_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
      $finish;
   end

endmodule
